// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle between a DMA-side master and the on-chip SRAM responder.
// The master modport drives requests and write data; the slave modport drives responses.
interface axi_sram_slave_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4
) ();
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;

    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 responder backed by an on-chip SRAM of DEPTH words at BASE_ADDR.
// Independent read and write FSMs, one outstanding burst each, FIXED/INCR/WRAP sequencing.
module axi_sram_slave #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       ID_W      = 4,
    parameter int unsigned       DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
    input logic            clk,
    input logic            rst_n,
    axi_sram_slave_if.slave io_axi
);
    localparam int unsigned       STRB_W     = DATA_W / 8;
    localparam int unsigned       LSB        = $clog2(STRB_W);
    localparam int unsigned       IDX_W      = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN       = ADDR_W'(DEPTH * STRB_W);
    localparam logic [1:0]        RespOkay   = 2'b00;
    localparam logic [1:0]        RespSlvErr = 2'b10;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic [0:0] {RIdle, RData} r_state_e;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [2:0] size,
                                                    input logic [7:0] len,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] nbytes;
        logic [ADDR_W-1:0] total;
        logic [ADDR_W-1:0] incr;
        nbytes = ADDR_W'(1) << size;
        total  = nbytes * (ADDR_W'(len) + ADDR_W'(1));
        incr   = (addr & ~(nbytes - ADDR_W'(1))) + nbytes;
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~(total - ADDR_W'(1))) | (incr & (total - ADDR_W'(1)));
            default: return incr;
        endcase
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return (addr >= BASE_ADDR) && ((addr - BASE_ADDR) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> LSB);
    endfunction

    // Illegal WRAP shape poisons the whole burst but keeps its beat count.
    function automatic logic wrap_bad(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
        return (burst == 2'b10) && (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || (size > 3'd3));
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write channel
    w_state_e          r_wstate;
    logic              r_awready;
    logic              r_wready;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic [ID_W-1:0]   r_bid;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_wlen;
    logic [2:0]        r_wsize;
    logic [1:0]        r_wburst;
    logic [7:0]        r_wcnt;
    logic              r_werr;
    logic              r_wbad;

    logic              w_whs;
    logic              w_wlast_beat;
    logic              w_wbeat_err;
    logic              w_mem_we;
    logic [IDX_W-1:0]  w_widx;

    assign w_whs        = r_wready && io_axi.wvalid;
    assign w_wlast_beat = (r_wcnt == r_wlen);
    assign w_wbeat_err  = !in_range(r_waddr) || (io_axi.wlast != w_wlast_beat);
    assign w_mem_we     = w_whs && in_range(r_waddr) && !r_wbad;
    assign w_widx       = word_idx(r_waddr);

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (io_axi.wstrb[i]) r_mem[w_widx][8*i +: 8] <= io_axi.wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate  <= WIdle;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RespOkay;
            r_bid     <= '0;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wsize   <= '0;
            r_wburst  <= '0;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
            r_wbad    <= 1'b0;
        end else begin
            case (r_wstate)
                WIdle: begin
                    if (io_axi.awvalid) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_bid     <= io_axi.awid;
                        r_waddr   <= io_axi.awaddr;
                        r_wlen    <= io_axi.awlen;
                        r_wsize   <= io_axi.awsize;
                        r_wburst  <= io_axi.awburst;
                        r_wcnt    <= '0;
                        r_werr    <= 1'b0;
                        r_wbad    <= wrap_bad(io_axi.awlen, io_axi.awsize, io_axi.awburst);
                        r_wstate  <= WData;
                    end
                end
                WData: begin
                    if (w_whs) begin
                        r_waddr <= next_addr(r_waddr, r_wsize, r_wlen, r_wburst);
                        r_wcnt  <= r_wcnt + 8'd1;
                        if (w_wbeat_err) r_werr <= 1'b1;
                        if (w_wlast_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || r_wbad || w_wbeat_err) ? RespSlvErr : RespOkay;
                            r_wstate <= WResp;
                        end
                    end
                end
                WResp: begin
                    if (io_axi.bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= WIdle;
                    end
                end
                default: r_wstate <= WIdle;
            endcase
        end
    end

    assign io_axi.awready = r_awready;
    assign io_axi.wready  = r_wready;
    assign io_axi.bvalid  = r_bvalid;
    assign io_axi.bresp   = r_bresp;
    assign io_axi.bid     = r_bid;

    // Read channel
    r_state_e          r_rstate;
    logic              r_arready;
    logic              r_rvalid;
    logic [ID_W-1:0]   r_rid;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic              r_rlast;
    logic [ADDR_W-1:0] r_raddr;
    logic [7:0]        r_rlen;
    logic [2:0]        r_rsize;
    logic [1:0]        r_rburst;
    logic [7:0]        r_rcnt;
    logic              r_rbad;

    logic              w_ridle;
    logic              w_rload;
    logic [ADDR_W-1:0] w_raddr;
    logic [7:0]        w_rlen;
    logic [2:0]        w_rsize;
    logic [1:0]        w_rburst;
    logic              w_rbad;
    logic              w_rok;
    logic [7:0]        w_rcnt_nxt;

    // In idle the first beat is taken straight from the AR request; afterwards from latched state.
    assign w_ridle    = (r_rstate == RIdle);
    assign w_rload    = w_ridle ? io_axi.arvalid : (io_axi.rready && !r_rlast);
    assign w_raddr    = w_ridle ? io_axi.araddr  : r_raddr;
    assign w_rlen     = w_ridle ? io_axi.arlen   : r_rlen;
    assign w_rsize    = w_ridle ? io_axi.arsize  : r_rsize;
    assign w_rburst   = w_ridle ? io_axi.arburst : r_rburst;
    assign w_rbad     = w_ridle ? wrap_bad(io_axi.arlen, io_axi.arsize, io_axi.arburst) : r_rbad;
    assign w_rok      = in_range(w_raddr) && !w_rbad;
    assign w_rcnt_nxt = w_ridle ? 8'd0 : r_rcnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate  <= RIdle;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_rresp   <= RespOkay;
            r_rlast   <= 1'b0;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rsize   <= '0;
            r_rburst  <= '0;
            r_rcnt    <= '0;
            r_rbad    <= 1'b0;
        end else begin
            if (w_rload) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rok ? r_mem[word_idx(w_raddr)] : '0;
                r_rresp  <= w_rok ? RespOkay : RespSlvErr;
                r_rlast  <= (w_rcnt_nxt == w_rlen);
                r_rcnt   <= w_rcnt_nxt;
                r_raddr  <= next_addr(w_raddr, w_rsize, w_rlen, w_rburst);
            end
            case (r_rstate)
                RIdle: begin
                    if (io_axi.arvalid) begin
                        r_arready <= 1'b0;
                        r_rid     <= io_axi.arid;
                        r_rlen    <= io_axi.arlen;
                        r_rsize   <= io_axi.arsize;
                        r_rburst  <= io_axi.arburst;
                        r_rbad    <= w_rbad;
                        r_rstate  <= RData;
                    end
                end
                RData: begin
                    if (io_axi.rready && r_rlast) begin
                        r_rvalid  <= 1'b0;
                        r_rlast   <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= RIdle;
                    end
                end
                default: r_rstate <= RIdle;
            endcase
        end
    end

    assign io_axi.arready = r_arready;
    assign io_axi.rvalid  = r_rvalid;
    assign io_axi.rid     = r_rid;
    assign io_axi.rdata   = r_rdata;
    assign io_axi.rresp   = r_rresp;
    assign io_axi.rlast   = r_rlast;
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: bursts, strobes, WRAP, range errors, back-pressure, reset.
module tb_axi_sram_slave;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] LASTW = 32'h8000_1FF8;
    localparam logic [1:0]  FIX   = 2'b00;
    localparam logic [1:0]  INC   = 2'b01;
    localparam logic [1:0]  WRP   = 2'b10;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [63:0] rd_data [256];
    logic [1:0]  rd_resp [256];
    logic        rd_last [256];
    int          rd_n;
    int          rd_gap;
    logic        rd_lat1;

    always #5 clk = ~clk;

    axi_sram_slave_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) bus ();

    axi_sram_slave #(
        .ADDR_W(32), .DATA_W(64), .ID_W(4), .DEPTH(1024), .BASE_ADDR(32'h8000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_axi(bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr;
        bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        while (!bus.awready && n < 50) begin tick(); n++; end
        if (!bus.awready) chk("aw_ready_timeout", 64'(bus.awready), 64'd1);
        tick();
        bus.awvalid = 1'b0;
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input logic [63:0] d0, input logic [63:0] step,
                               input logic [7:0] strb, input bit bad_wlast, input int bstall,
                               output logic [1:0] o_resp, output logic [3:0] o_bid);
        int n;
        do_aw(id, addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = d0 + step * 64'(i);
            bus.wstrb  = strb;
            bus.wlast  = bad_wlast ? 1'b0 : (i == int'(len));
            n = 0;
            while (!bus.wready && n < 50) begin tick(); n++; end
            if (!bus.wready) chk("w_ready_timeout", 64'(bus.wready), 64'd1);
            tick();
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        n = 0;
        while (!bus.bvalid && n < 50) begin tick(); n++; end
        if (!bus.bvalid) chk("b_valid_timeout", 64'(bus.bvalid), 64'd1);
        o_resp = bus.bresp;
        o_bid  = bus.bid;
        repeat (bstall) begin
            tick();
            chk("b_hold", 64'({bus.bvalid, bus.bid, bus.bresp}), 64'({1'b1, o_bid, o_resp}));
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("b_drop", 64'(bus.bvalid), 64'd0);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input int stall_beat, input int stall_n);
        int n = 0;
        bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr;
        bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        while (!bus.arready && n < 50) begin tick(); n++; end
        if (!bus.arready) chk("ar_ready_timeout", 64'(bus.arready), 64'd1);
        tick();
        bus.arvalid = 1'b0;
        rd_lat1 = bus.rvalid;
        rd_n = 0;
        rd_gap = 0;
        bus.rready = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!bus.rvalid && n < 50) begin tick(); n++; rd_gap++; end
            if (!bus.rvalid) chk("r_valid_timeout", 64'(bus.rvalid), 64'd1);
            rd_data[b] = bus.rdata;
            rd_resp[b] = bus.rresp;
            rd_last[b] = bus.rlast;
            rd_n++;
            chk("r_id", 64'(bus.rid), 64'(id));
            if (b == stall_beat) begin
                bus.rready = 1'b0;
                repeat (stall_n) begin
                    tick();
                    chk("r_hold_data", bus.rdata, rd_data[b]);
                    chk("r_hold_ctl", 64'({bus.rvalid, bus.rlast, bus.rresp}),
                        64'({1'b1, rd_last[b], rd_resp[b]}));
                end
                bus.rready = 1'b1;
            end
            tick();
        end
        bus.rready = 1'b0;
        chk("r_end_no_extra", 64'(bus.rvalid), 64'd0);
    endtask

    initial begin
        logic [1:0] resp;
        logic [3:0] bidv;
        bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0;
        bus.awburst = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
        bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0;
        bus.arsize = 0; bus.arburst = 0; bus.rready = 0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'({bus.awready, bus.arready, bus.wready}), 64'b110);
        chk("rst_valid", 64'({bus.bvalid, bus.rvalid, bus.rlast}), 64'b000);
        chk("rst_resp_id", 64'({bus.bresp, bus.rresp, bus.bid, bus.rid}), 64'd0);
        chk("rst_rdata", bus.rdata, 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // 1: INCR 4-beat write then read back
        write_burst(4'h3, BASE, 8'd3, 3'd3, INC, 64'h11, 64'h11, 8'hFF, 1'b0, 0, resp, bidv);
        chk("t1_bresp", 64'(resp), 64'd0);
        chk("t1_bid", 64'(bidv), 64'h3);
        read_burst(4'h9, BASE, 8'd3, 3'd3, INC, -1, 0);
        chk("t1_latency", 64'(rd_lat1), 64'd1);
        chk("t1_beats", 64'(rd_n), 64'd4);
        chk("t1_no_bubble", 64'(rd_gap), 64'd0);
        chk("t1_d0", rd_data[0], 64'h11);
        chk("t1_d1", rd_data[1], 64'h22);
        chk("t1_d2", rd_data[2], 64'h33);
        chk("t1_d3", rd_data[3], 64'h44);
        chk("t1_last", 64'({rd_last[0], rd_last[1], rd_last[2], rd_last[3]}), 64'b0001);
        chk("t1_resp", 64'({rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}), 64'd0);

        // 2: byte strobes over a zeroed word
        write_burst(4'h1, BASE + 32'h40, 8'd0, 3'd3, INC, 64'h0, 64'h0, 8'hFF, 1'b0, 0, resp, bidv);
        write_burst(4'h1, BASE + 32'h40, 8'd0, 3'd3, INC, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'h0F,
                    1'b0, 0, resp, bidv);
        read_burst(4'h1, BASE + 32'h40, 8'd0, 3'd3, INC, -1, 0);
        chk("t2_strb", rd_data[0], 64'h0000_0000_FFFF_FFFF);
        chk("t2_resp", 64'(rd_resp[0]), 64'd0);

        // 3: WRAP from word 2 lands on words 2,3,0,1
        write_burst(4'h2, BASE + 32'h10, 8'd3, 3'd3, WRP, 64'hA0, 64'h1, 8'hFF, 1'b0, 0, resp, bidv);
        chk("t3_wrap_bresp", 64'(resp), 64'd0);
        read_burst(4'h4, BASE, 8'd3, 3'd3, INC, -1, 0);
        chk("t3_w0", rd_data[0], 64'hA2);
        chk("t3_w1", rd_data[1], 64'hA3);
        chk("t3_w2", rd_data[2], 64'hA0);
        chk("t3_w3", rd_data[3], 64'hA1);
        // WRAP read with rready held low 5 cycles on beat 1
        read_burst(4'h5, BASE + 32'h10, 8'd3, 3'd3, WRP, 1, 5);
        chk("t5_stall_beats", 64'(rd_n), 64'd4);
        chk("t5_stall_d0", rd_data[0], 64'hA0);
        chk("t5_stall_d1", rd_data[1], 64'hA1);
        chk("t5_stall_d2", rd_data[2], 64'hA2);
        chk("t5_stall_d3", rd_data[3], 64'hA3);
        // Illegal WRAP length
        write_burst(4'h2, BASE + 32'h10, 8'd2, 3'd3, WRP, 64'hEE, 64'h0, 8'hFF, 1'b0, 0, resp, bidv);
        chk("t3_badwrap_bresp", 64'(resp), 64'd2);
        read_burst(4'h4, BASE, 8'd3, 3'd3, INC, -1, 0);
        chk("t3_badwrap_w0", rd_data[0], 64'hA2);
        chk("t3_badwrap_w2", rd_data[2], 64'hA0);
        chk("t3_badwrap_w3", rd_data[3], 64'hA1);
        read_burst(4'h6, BASE + 32'h10, 8'd2, 3'd3, WRP, -1, 0);
        chk("t3_badwrap_rbeats", 64'(rd_n), 64'd3);
        chk("t3_badwrap_rresp", 64'({rd_resp[0], rd_resp[1], rd_resp[2]}), 64'b101010);
        chk("t3_badwrap_rlast", 64'({rd_last[0], rd_last[1], rd_last[2]}), 64'b001);

        // 4: last word plus one beat past the end; bready held low 3 cycles
        write_burst(4'hA, LASTW, 8'd1, 3'd3, INC, 64'h5A0, 64'h1, 8'hFF, 1'b0, 3, resp, bidv);
        chk("t4_wr_bresp", 64'(resp), 64'd2);
        chk("t4_wr_bid", 64'(bidv), 64'hA);
        read_burst(4'hB, LASTW, 8'd1, 3'd3, INC, -1, 0);
        chk("t4_rd_d0", rd_data[0], 64'h5A0);
        chk("t4_rd_r0", 64'(rd_resp[0]), 64'd0);
        chk("t4_rd_d1", rd_data[1], 64'd0);
        chk("t4_rd_r1", 64'(rd_resp[1]), 64'd2);
        read_burst(4'hB, BASE, 8'd0, 3'd3, INC, -1, 0);
        chk("t4_no_wrap_w0", rd_data[0], 64'hA2);

        // FIXED 256-beat read
        read_burst(4'hC, BASE, 8'd255, 3'd3, FIX, -1, 0);
        chk("fix_beats", 64'(rd_n), 64'd256);
        chk("fix_no_bubble", 64'(rd_gap), 64'd0);
        chk("fix_d255", rd_data[255], 64'hA2);
        chk("fix_last", 64'({rd_last[0], rd_last[254], rd_last[255]}), 64'b001);

        // wlast never asserted: data sequenced by awlen, response SLVERR
        write_burst(4'h7, BASE + 32'h80, 8'd1, 3'd3, INC, 64'h77, 64'h1, 8'hFF, 1'b1, 0, resp, bidv);
        chk("wlast_bresp", 64'(resp), 64'd2);
        read_burst(4'h7, BASE + 32'h80, 8'd1, 3'd3, INC, -1, 0);
        chk("wlast_d0", rd_data[0], 64'h77);
        chk("wlast_d1", rd_data[1], 64'h78);

        // 5: AW and AR together; the W beat coincides with the read of the same word
        bus.awvalid = 1'b1; bus.awid = 4'h5; bus.awaddr = BASE + 32'h88;
        bus.awlen = 8'd0; bus.awsize = 3'd3; bus.awburst = INC;
        bus.arvalid = 1'b1; bus.arid = 4'h6; bus.araddr = BASE + 32'h80;
        bus.arlen = 8'd1; bus.arsize = 3'd3; bus.arburst = INC;
        bus.rready = 1'b1;
        chk("c_both_ready", 64'({bus.awready, bus.arready}), 64'b11);
        tick();
        bus.awvalid = 1'b0;
        bus.arvalid = 1'b0;
        chk("c_rvalid", 64'(bus.rvalid), 64'd1);
        chk("c_d0", bus.rdata, 64'h77);
        chk("c_wready", 64'(bus.wready), 64'd1);
        bus.wvalid = 1'b1; bus.wdata = 64'hC0FFEE; bus.wstrb = 8'hFF; bus.wlast = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        bus.wlast = 1'b0;
        chk("c_d1_old", bus.rdata, 64'h78);
        chk("c_rlast", 64'(bus.rlast), 64'd1);
        chk("c_b", 64'({bus.bvalid, bus.bid, bus.bresp}), 64'({1'b1, 4'h5, 2'b00}));
        tick();
        bus.rready = 1'b0;
        chk("c_r_done", 64'(bus.rvalid), 64'd0);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        read_burst(4'h6, BASE + 32'h88, 8'd0, 3'd3, INC, -1, 0);
        chk("c_new", rd_data[0], 64'hC0FFEE);

        // 6: reset during beat 2 of a 4-beat write
        do_aw(4'h7, BASE + 32'h100, 8'd3, 3'd3, INC);
        for (int i = 0; i < 2; i++) begin
            bus.wvalid = 1'b1; bus.wdata = 64'hD0 + 64'(i); bus.wstrb = 8'hFF; bus.wlast = 1'b0;
            tick();
        end
        bus.wdata = 64'hD2;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_async", 64'({bus.awready, bus.bvalid, bus.wready}), 64'b100);
        bus.wvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_no_bvalid", 64'(bus.bvalid), 64'd0);
        write_burst(4'h8, BASE + 32'h100, 8'd3, 3'd3, INC, 64'hE0, 64'h1, 8'hFF, 1'b0, 0, resp, bidv);
        chk("t6_bresp", 64'(resp), 64'd0);
        chk("t6_bid", 64'(bidv), 64'h8);
        read_burst(4'h8, BASE + 32'h100, 8'd3, 3'd3, INC, -1, 0);
        chk("t6_d0", rd_data[0], 64'hE0);
        chk("t6_d3", rd_data[3], 64'hE3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
